// File: rtl/adc_pkg.sv
// Shared types and build constants for the discrete SAR ADC controller
// and its companion sequencers.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    localparam int ADC_WIDTH      = 8;
    localparam int SETTLE_DEFAULT = 1000;

endpackage

// File: rtl/settle_timer.sv
// Loadable 16-bit down-counter that parks at zero; also used by the
// calibration sequencer.
module settle_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_zero
);

    logic [15:0] r_cnt;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == 16'd0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives R-2R DAC trial codes MSB first,
// waits for settling, and resolves one bit per step from the debounced comparator.
module sar_adc_ctrl
    import adc_pkg::*;
#(
    parameter int WIDTH         = ADC_WIDTH,
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             comp_db,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [15:0]      RELOAD   = 16'(SETTLE_CYCLES - 1);

    sar_state_t       r_state;
    sar_state_t       w_next_state;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] w_code_next;
    logic [WIDTH-1:0] w_decided;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_load;
    logic             w_publish;
    logic             w_zero;
    logic             r_busy;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;

    settle_timer u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (RELOAD),
        .o_zero     (w_zero)
    );

    // Next-state, trial-code and bit-index logic.
    always_comb begin
        w_next_state = r_state;
        w_code_next  = r_code;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        w_publish    = 1'b0;
        w_decided    = r_code;
        w_decided[r_idx] = r_code[r_idx] & comp_db;
        case (r_state)
            IDLE: begin
                if (start || cont) begin
                    w_next_state = SETTLE;
                    w_code_next  = MSB_CODE;
                    w_idx_next   = IDX_TOP;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SETTLE: begin
                if (w_zero) begin
                    w_next_state = DECIDE;
                end else begin
                    w_next_state = SETTLE;
                end
            end
            DECIDE: begin
                w_code_next = w_decided;
                if (r_idx == '0) begin
                    w_next_state = DONE;
                    w_publish    = 1'b1;
                end else begin
                    w_code_next[r_idx - IDX_ONE] = 1'b1;
                    w_idx_next   = r_idx - IDX_ONE;
                    w_load       = 1'b1;
                    w_next_state = SETTLE;
                end
            end
            DONE: begin
                if (cont) begin
                    w_next_state = SETTLE;
                    w_code_next  = MSB_CODE;
                    w_idx_next   = IDX_TOP;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, code and output registers; result is captured on the final decision
    // so it appears in the same cycle as the valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_code         <= '0;
            r_idx          <= '0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_code         <= w_code_next;
            r_idx          <= w_idx_next;
            r_busy         <= (w_next_state != IDLE);
            r_result_valid <= w_publish;
            if (w_publish) begin
                r_result <= w_code_next;
            end else begin
                r_result <= r_result;
            end
        end
    end

    assign dac_code     = r_code;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl (WIDTH=8, SETTLE_CYCLES=4): stimulus queues
// expected observations, a negedge monitor pops and compares them.
module tb_sar_adc_ctrl;

    localparam int W     = 8;
    localparam int SC    = 4;
    localparam int T_RES = 1 + W * (SC + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         cont = 1'b0;
    logic         comp_db;
    logic [7:0]   vin = 8'h00;
    logic [7:0]   dac_code;
    logic         busy;
    logic [7:0]   result;
    logic         result_valid;

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cont         (cont),
        .comp_db      (comp_db),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    assign comp_db = (vin >= dac_code);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    exp_t eq[$];
    exp_t rq[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] tr_ff[8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] tr_00[8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] tr_5a[8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int k, input int v);
        exp_t e;
        e.cyc = c; e.kind = k; e.val = v;
        eq.push_back(e);
    endtask

    task automatic push_res(input int c, input int v);
        exp_t e;
        e.cyc = c; e.kind = 3; e.val = v;
        rq.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: scheduled observations plus every result_valid pulse.
    always @(negedge clk) begin
        for (int i = eq.size() - 1; i >= 0; i--) begin
            if (eq[i].cyc == cyc) begin
                case (eq[i].kind)
                    0:       chk("dac_code", int'(dac_code), eq[i].val);
                    1:       chk("busy", int'(busy), eq[i].val);
                    default: chk("result_hold", int'(result), eq[i].val);
                endcase
                eq.delete(i);
            end
        end
        if (result_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid at cycle %0d: got result_valid=1, expected 0", cyc);
            end else begin
                exp_t e;
                e = rq.pop_front();
                chk("result", int'(result), e.val);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_single(input logic [7:0] v, input logic [7:0] trials[8],
                              input logic [7:0] res, input bit all_busy, input int restart_at);
        int base;
        @(negedge clk);
        vin = v;
        base = cyc;
        start = 1'b1;
        for (int k = 0; k < 8; k++) push(base + 1 + 5 * k, 0, int'(trials[k]));
        if (all_busy) begin
            for (int c = 1; c <= T_RES; c++) push(base + c, 1, 1);
        end else begin
            push(base + 1, 1, 1);
            push(base + T_RES, 1, 1);
        end
        push(base + T_RES, 0, int'(res));
        push(base + T_RES + 1, 1, 0);
        push(base + T_RES + 1, 0, int'(res));
        push(base + T_RES + 5, 2, int'(res));
        push_res(base + T_RES, int'(res));
        @(negedge clk);
        start = 1'b0;
        if (restart_at > 0) begin
            wait_until(base + restart_at);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_until(base + T_RES + 12);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_dac_code", int'(dac_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_single(8'hFF, tr_ff, 8'hFF, 1'b0, 0);
        run_single(8'h00, tr_00, 8'h00, 1'b0, 0);
        run_single(8'h5A, tr_5a, 8'h5A, 1'b1, 0);
        run_single(8'h5A, tr_5a, 8'h5A, 1'b0, 10);

        // Reset in the middle of a conversion.
        @(negedge clk);
        vin = 8'h5A;
        base = cyc;
        start = 1'b1;
        push(base + 19, 1, 1);
        push(base + 20, 0, 8'h50);
        push(base + 21, 0, 0);
        push(base + 21, 1, 0);
        push(base + 21, 2, 0);
        push(base + 30, 1, 0);
        push(base + 45, 2, 0);
        @(negedge clk);
        start = 1'b0;
        wait_until(base + 20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_until(base + 60);

        // Continuous mode with an input change between conversions.
        @(negedge clk);
        vin = 8'h33;
        base = cyc;
        cont = 1'b1;
        push_res(base + 41, 8'h33);
        push_res(base + 82, 8'h33);
        push_res(base + 123, 8'hC8);
        push_res(base + 164, 8'hC8);
        push(base + 42, 1, 1);
        push(base + 83, 1, 1);
        push(base + 124, 1, 1);
        push(base + 164, 1, 1);
        push(base + 165, 1, 0);
        push(base + 165, 0, 8'hC8);
        wait_until(base + 82);
        vin = 8'hC8;
        wait_until(base + 130);
        cont = 1'b0;
        wait_until(base + 190);

        chk("pending_observations", eq.size(), 0);
        chk("pending_results", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
